// File: rtl/march_pkg.sv
// March C- element table and controller state encoding shared by the
// sequencer and its comparator.
package march_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RD    = 3'd2,
        ST_OP    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int         NUM_ELEM  = 6;
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

    // Address direction of an element: 1 = ascending, 0 = descending.
    function automatic logic dir(input logic [2:0] e);
        case (e)
            3'd3, 3'd4: dir = 1'b0;
            default:    dir = 1'b1;
        endcase
    endfunction

    function automatic logic has_read(input logic [2:0] e);
        case (e)
            3'd0:    has_read = 1'b0;
            default: has_read = 1'b1;
        endcase
    endfunction

    function automatic logic has_write(input logic [2:0] e);
        case (e)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: has_write = 1'b1;
            default:                      has_write = 1'b0;
        endcase
    endfunction

    function automatic logic rd_bg(input logic [2:0] e);
        case (e)
            3'd2, 3'd4: rd_bg = 1'b1;
            default:    rd_bg = 1'b0;
        endcase
    endfunction

    function automatic logic wr_bg(input logic [2:0] e);
        case (e)
            3'd1, 3'd3: wr_bg = 1'b1;
            default:    wr_bg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/march_ctrl_if.sv
// Bundle between the March sequencer, the address generator and the
// memory under test.
interface march_ctrl_if #(
    parameter int Adr_size  = 4,
    parameter int Data_size = 8
);
    logic [Adr_size-1:0]  adress;
    logic                 c_out;
    logic                 rst_adr;
    logic                 pr_res_adr;
    logic                 enable;
    logic                 up_down;
    logic                 mem_re;
    logic                 mem_we;
    logic [Data_size-1:0] mem_wdata;
    logic [Data_size-1:0] mem_rdata;

    modport master (
        input  adress, c_out, mem_rdata,
        output rst_adr, pr_res_adr, enable, up_down, mem_re, mem_we, mem_wdata
    );

    modport slave (
        output adress, c_out, mem_rdata,
        input  rst_adr, pr_res_adr, enable, up_down, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/march_cmp.sv
// Read-data comparator with a sticky fail flag that keeps the location
// of the first mismatch of a run.
module march_cmp #(
    parameter int Adr_size  = 4,
    parameter int Data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmp_en,
    input  logic                 clr,
    input  logic [Adr_size-1:0]  adress,
    input  logic [2:0]           element,
    input  logic [Data_size-1:0] mem_rdata,
    input  logic [Data_size-1:0] expected,
    output logic                 fail,
    output logic [Adr_size-1:0]  fail_adr,
    output logic [2:0]           fail_elem
);

    logic                fail_r;
    logic [Adr_size-1:0] fail_adr_r;
    logic [2:0]          fail_elem_r;
    logic                mismatch_s;

    assign mismatch_s = cmp_en && (mem_rdata != expected);

    // Capture only the first mismatch; later ones leave the record alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_r      <= 1'b0;
            fail_adr_r  <= '0;
            fail_elem_r <= 3'd0;
        end else if (clr) begin
            fail_r      <= 1'b0;
            fail_adr_r  <= '0;
            fail_elem_r <= 3'd0;
        end else if (mismatch_s && !fail_r) begin
            fail_r      <= 1'b1;
            fail_adr_r  <= adress;
            fail_elem_r <= element;
        end else begin
            fail_r      <= fail_r;
            fail_adr_r  <= fail_adr_r;
            fail_elem_r <= fail_elem_r;
        end
    end

    assign fail      = fail_r;
    assign fail_adr  = fail_adr_r;
    assign fail_elem = fail_elem_r;

endmodule

// File: rtl/march_ctrl.sv
// March C- BIST sequencer: steps the address generator through the six
// elements, strobes the memory and reports done / first failure.
module march_ctrl
    import march_pkg::*;
#(
    parameter int Adr_size  = 4,
    parameter int Data_size = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    march_ctrl_if.master        bus,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [Adr_size-1:0] fail_adr,
    output logic [2:0]          fail_elem
);

    state_t                state_r, state_s;
    logic [2:0]            elem_r, elem_s;
    logic                  rst_adr_s, pr_res_adr_s, enable_s, up_down_s;
    logic                  mem_re_s, mem_we_s;
    logic [Data_size-1:0]  mem_wdata_s;
    logic                  cmp_en_s, clr_s;
    logic [Data_size-1:0]  expected_s;

    // State and element-index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            elem_r  <= 3'd0;
        end else begin
            state_r <= state_s;
            elem_r  <= elem_s;
        end
    end

    // Next-state logic and Moore decode of the generator and memory strobes.
    always_comb begin
        state_s      = state_r;
        elem_s       = elem_r;
        rst_adr_s    = 1'b0;
        pr_res_adr_s = 1'b0;
        enable_s     = 1'b0;
        up_down_s    = 1'b0;
        mem_re_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_wdata_s  = '0;
        cmp_en_s     = 1'b0;
        clr_s        = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_SETUP;
                    elem_s  = 3'd0;
                    clr_s   = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SETUP: begin
                rst_adr_s    = dir(elem_r);
                pr_res_adr_s = !dir(elem_r);
                up_down_s    = dir(elem_r);
                state_s      = has_read(elem_r) ? ST_RD : ST_OP;
            end
            ST_RD: begin
                mem_re_s  = 1'b1;
                up_down_s = dir(elem_r);
                state_s   = ST_OP;
            end
            ST_OP: begin
                up_down_s   = dir(elem_r);
                enable_s    = 1'b1;
                mem_we_s    = has_write(elem_r);
                mem_wdata_s = has_write(elem_r) ? {Data_size{wr_bg(elem_r)}} : '0;
                cmp_en_s    = has_read(elem_r);
                // c_out marks the element's last address; the step taken here is discarded.
                if (bus.c_out) begin
                    if (elem_r == LAST_ELEM) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SETUP;
                        elem_s  = elem_r + 3'd1;
                    end
                end else begin
                    state_s = has_read(elem_r) ? ST_RD : ST_OP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                elem_s  = 3'd0;
            end
        endcase
    end

    assign expected_s = {Data_size{rd_bg(elem_r)}};

    march_cmp #(
        .Adr_size  (Adr_size),
        .Data_size (Data_size)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .cmp_en    (cmp_en_s),
        .clr       (clr_s),
        .adress    (bus.adress),
        .element   (elem_r),
        .mem_rdata (bus.mem_rdata),
        .expected  (expected_s),
        .fail      (fail),
        .fail_adr  (fail_adr),
        .fail_elem (fail_elem)
    );

    assign bus.rst_adr    = rst_adr_s;
    assign bus.pr_res_adr = pr_res_adr_s;
    assign bus.enable     = enable_s;
    assign bus.up_down    = up_down_s;
    assign bus.mem_re     = mem_re_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_wdata  = mem_wdata_s;

    assign busy = (state_r == ST_SETUP) || (state_r == ST_RD) || (state_r == ST_OP);
    assign done = (state_r == ST_DONE);

endmodule

// File: tb/tb_march_ctrl.sv
// Bench for march_ctrl: address-generator and faulty-memory models, a
// cycle trace and first-fail prediction built from the March C- table.
module tb_march_ctrl;

    localparam int AW      = 4;
    localparam int DW      = 8;
    localparam int N       = 1 << AW;
    localparam int RUN_LEN = 11 * N + 6;

    // Element table, bit e describes element e.
    localparam logic [5:0] UP_E  = 6'b100111;
    localparam logic [5:0] RD_E  = 6'b111110;
    localparam logic [5:0] WR_E  = 6'b011111;
    localparam logic [5:0] RBG_E = 6'b010100;
    localparam logic [5:0] WBG_E = 6'b001010;

    typedef struct packed {
        logic [7:0]    ctl;   // rst_adr,pr_res_adr,enable,up_down,re,we,busy,done
        logic [DW-1:0] wd;
        logic [AW-1:0] adr;
        logic          care;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, fail;
    logic [AW-1:0] fail_adr;
    logic [2:0]    fail_elem;

    int n_chk = 0;
    int n_err = 0;

    march_ctrl_if #(.Adr_size(AW), .Data_size(DW)) bus ();

    march_ctrl #(.Adr_size(AW), .Data_size(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_adr  (fail_adr),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    // Address generator model.
    logic [AW-1:0] gen_adr;
    always @(posedge clk or posedge rst) begin
        if (rst)                 gen_adr <= '0;
        else if (bus.rst_adr)    gen_adr <= '0;
        else if (bus.pr_res_adr) gen_adr <= '1;
        else if (bus.enable)     gen_adr <= bus.up_down ? gen_adr + 1'b1 : gen_adr - 1'b1;
    end
    assign bus.adress = gen_adr;
    assign bus.c_out  = bus.up_down ? (gen_adr == '1) : (gen_adr == '0);

    // Fault description: 0 none, 1 stuck bits at f_adr, 2 writing zeros to f_adr inverts f_vict.
    int            fault_kind = 0;
    logic [AW-1:0] f_adr = '0;
    logic [AW-1:0] f_vict = '0;
    logic [DW-1:0] f_mask = '0;
    logic          f_val = 1'b0;

    function automatic logic [DW-1:0] cell_view(input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (fault_kind == 1 && a == f_adr) return f_val ? (d | f_mask) : (d & ~f_mask);
        return d;
    endfunction

    // Memory under test with one-cycle read latency.
    logic [DW-1:0] hw_mem [N];
    logic [DW-1:0] rdata;
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    always @(posedge clk) begin
        if (bus.mem_re) begin
            rdata  <= cell_view(bus.adress, hw_mem[bus.adress]);
            rd_cnt <= rd_cnt + 1;
        end
        if (bus.mem_we) begin
            hw_mem[bus.adress] <= cell_view(bus.adress, bus.mem_wdata);
            if (fault_kind == 2 && bus.adress == f_adr && bus.mem_wdata == '0)
                hw_mem[f_vict] <= ~hw_mem[f_vict];
            wr_cnt <= wr_cnt + 1;
        end
    end
    assign bus.mem_rdata = rdata;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk the March C- algorithm over a copy of the memory.
    logic [DW-1:0] ref_mem [N];
    task automatic predict(output logic pf, output logic [AW-1:0] pa, output logic [2:0] pe);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        pf = 1'b0; pa = '0; pe = 3'd0;
        for (int i = 0; i < N; i++) ref_mem[i] = hw_mem[i];
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                a = UP_E[e] ? AW'(k) : AW'(N - 1 - k);
                if (RD_E[e]) begin
                    v = cell_view(a, ref_mem[a]);
                    if (v !== {DW{RBG_E[e]}} && !pf) begin
                        pf = 1'b1; pa = a; pe = 3'(e);
                    end
                end
                if (WR_E[e]) begin
                    ref_mem[a] = cell_view(a, {DW{WBG_E[e]}});
                    if (fault_kind == 2 && a == f_adr && WBG_E[e] == 1'b0)
                        ref_mem[f_vict] = ~ref_mem[f_vict];
                end
            end
        end
    endtask

    function automatic exp_t mk(input logic [7:0] ctl, input logic [DW-1:0] wd,
                                input logic [AW-1:0] adr, input logic care);
        exp_t x;
        x.ctl = ctl; x.wd = wd; x.adr = adr; x.care = care;
        return x;
    endfunction

    // Expected per-cycle trace: SETUP, then (RD,) OP for every address of each element.
    exp_t exp_q [$];
    task automatic build_trace();
        logic          up;
        logic [AW-1:0] a;
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            up = UP_E[e];
            exp_q.push_back(mk({up, !up, 1'b0, up, 1'b0, 1'b0, 1'b1, 1'b0}, '0, '0, 1'b0));
            for (int k = 0; k < N; k++) begin
                a = up ? AW'(k) : AW'(N - 1 - k);
                if (RD_E[e])
                    exp_q.push_back(mk({3'b000, up, 1'b1, 1'b0, 1'b1, 1'b0}, '0, a, 1'b1));
                exp_q.push_back(mk({3'b001, up, 1'b0, WR_E[e], 1'b1, 1'b0},
                                   WR_E[e] ? {DW{WBG_E[e]}} : '0, a, 1'b1));
            end
        end
    endtask

    task automatic run_march(input string tag, input bit hold, input bit already);
        logic          pf;
        logic [AW-1:0] pa;
        logic [2:0]    pe;
        int            rd0, wr0;
        exp_t          ex, ob;
        predict(pf, pa, pe);
        build_trace();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        if (!already) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int i = 0; i < RUN_LEN; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_eq({tag, ".clr"}, 64'({done, fail, fail_adr, fail_elem}), 64'd0);
                if (!hold) start = 1'b0;
            end
            ex     = exp_q[i];
            ob.ctl = {bus.rst_adr, bus.pr_res_adr, bus.enable, bus.up_down,
                      bus.mem_re, bus.mem_we, busy, done};
            ob.wd   = ex.ctl[2] ? bus.mem_wdata : '0;
            ob.adr  = ex.care ? bus.adress : '0;
            ob.care = ex.care;
            check_eq($sformatf("%s.cyc%0d", tag, i), 64'(ob), 64'(ex));
        end
        @(negedge clk);
        check_eq({tag, ".done"}, 64'({busy, done}), 64'(2'b01));
        check_eq({tag, ".fail"}, 64'({fail, fail_adr, fail_elem}), 64'({pf, pa, pe}));
        check_eq({tag, ".reads"}, 64'(rd_cnt - rd0), 64'(5 * N));
        check_eq({tag, ".writes"}, 64'(wr_cnt - wr0), 64'(N + 4 * N));
        if (!hold) begin
            repeat (3) @(negedge clk);
            check_eq({tag, ".hold"}, 64'({busy, done, fail, fail_adr, fail_elem}),
                     64'({1'b0, 1'b1, pf, pa, pe}));
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.rst_adr, bus.pr_res_adr, bus.enable, bus.up_down, bus.mem_re,
                    bus.mem_we, bus.mem_wdata, busy, done, fail, fail_adr, fail_elem});
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset", all_outs(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle", all_outs(), 64'd0);

        // Fault-free run; memory must end all zeros.
        run_march("clean", 1'b0, 1'b0);
        for (int i = 0; i < N; i++)
            check_eq($sformatf("mem%0d", i), 64'(hw_mem[i]), 64'd0);

        // Stuck-at-1 on bit 0 of address 5.
        fault_kind = 1; f_adr = 4'd5; f_mask = 8'h01; f_val = 1'b1;
        run_march("sa1", 1'b0, 1'b0);
        check_eq("sa1.loc", 64'({fail, fail_adr, fail_elem}), 64'({1'b1, 4'd5, 3'd1}));

        // Reset in the middle of element 2 aborts immediately.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("mid.busy", 64'({busy, bus.up_down}), 64'(2'b11));
        #2 rst = 1'b1;
        #1 check_eq("mid.rst", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("mid.after", all_outs(), 64'd0);
        fault_kind = 0;
        run_march("rerun", 1'b0, 1'b0);

        // Start held through a run, then restarted straight from DONE.
        fault_kind = 1; f_adr = 4'd5; f_mask = 8'h01; f_val = 1'b1;
        run_march("held", 1'b1, 1'b0);
        fault_kind = 0;
        run_march("again", 1'b0, 1'b1);

        // Coupling fault: writing zeros to address 3 inverts address 4.
        fault_kind = 2; f_adr = 4'd3; f_vict = 4'd4;
        run_march("cf", 1'b0, 1'b0);
        check_eq("cf.loc", 64'({fail, fail_adr, fail_elem}), 64'({1'b1, 4'd4, 3'd2}));

        // Randomised faults and start gaps.
        for (int r = 0; r < 4; r++) begin
            fault_kind = int'($urandom_range(0, 2));
            f_adr      = AW'($urandom_range(0, N - 1));
            f_vict     = f_adr + AW'($urandom_range(1, N - 1));
            f_mask     = DW'(1) << $urandom_range(0, DW - 1);
            f_val      = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_march($sformatf("rnd%0d", r), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
